keypad_decoder: RTL

KEYPAD_DECODER -- requirements
Module: keypad_decoder

---
 rtl/keypad_pkg.sv | 58 +++++
 rtl/lockout_timer.sv | 40 ++++
 rtl/keypad_decoder.sv | 101 ++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared numpad scan codes, decoder FSM encoding and the code-to-hole lookup
// Contents:
//   SC_KP*        PS/2 set-2 make codes of the numpad digit keys 1..9
//   NUM_HOLES     number of decodable holes (width of the held mask)
//   kp_state_e    decoder FSM states
//   code_to_hole  scan code -> hole index 1..9, 0 when unmapped
//   hole_mask     hole index -> one-hot held-mask bit, 0 for index 0
package keypad_pkg;

  localparam logic [7:0] SC_KP1 = 8'h69;
  localparam logic [7:0] SC_KP2 = 8'h72;
  localparam logic [7:0] SC_KP3 = 8'h7A;
  localparam logic [7:0] SC_KP4 = 8'h6B;
  localparam logic [7:0] SC_KP5 = 8'h73;
  localparam logic [7:0] SC_KP6 = 8'h74;
  localparam logic [7:0] SC_KP7 = 8'h6C;
  localparam logic [7:0] SC_KP8 = 8'h75;
  localparam logic [7:0] SC_KP9 = 8'h7D;

  localparam int unsigned NUM_HOLES = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT    = 2'd1,
    ST_LOCKOUT = 2'd2
  } kp_state_e;

  function automatic logic [3:0] code_to_hole(input logic [7:0] code);
    case (code)
      SC_KP1:  return 4'd1;
      SC_KP2:  return 4'd2;
      SC_KP3:  return 4'd3;
      SC_KP4:  return 4'd4;
      SC_KP5:  return 4'd5;
      SC_KP6:  return 4'd6;
      SC_KP7:  return 4'd7;
      SC_KP8:  return 4'd8;
      SC_KP9:  return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [NUM_HOLES-1:0] hole_mask(input logic [3:0] hole);
    case (hole)
      4'd1:    return 9'b000000001;
      4'd2:    return 9'b000000010;
      4'd3:    return 9'b000000100;
      4'd4:    return 9'b000001000;
      4'd5:    return 9'b000010000;
      4'd6:    return 9'b000100000;
      4'd7:    return 9'b001000000;
      4'd8:    return 9'b010000000;
      4'd9:    return 9'b100000000;
      default: return 9'b000000000;
    endcase
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// rtl/lockout_timer.sv - lockout down-counter between accepted presses
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset, clears the counter
//   start  load LOCKOUT_CYCLES-1 on the next edge
//   busy   counter is nonzero
module lockout_timer #(
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int unsigned CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(LOCKOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = LOAD;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy = (count_q != '0);

endmodule

// File: rtl/keypad_decoder.sv
// rtl/keypad_decoder.sv - numpad key events to debounced one-cycle hole pulses
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   key_valid      one-cycle strobe qualifying key_code/key_ext/key_break
//   key_code       PS/2 set-2 scan code
//   key_ext        event had an E0 prefix
//   key_break      event had an F0 prefix (release)
//   one_pulse_pos  hole 1..9 for one cycle per accepted press, else 0
//   hit            high exactly when one_pulse_pos is nonzero
//   held_mask      bit i-1 set while the key for hole i is held
//   press_cnt      accepted presses, wrapping
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [7:0]           key_code,
  input  logic                 key_ext,
  input  logic                 key_break,
  output logic [3:0]           one_pulse_pos,
  output logic                 hit,
  output logic [NUM_HOLES-1:0] held_mask,
  output logic [7:0]           press_cnt
);

  kp_state_e            state_q, state_d;
  logic [3:0]           pos_q, pos_d;
  logic                 hit_q, hit_d;
  logic [NUM_HOLES-1:0] held_q, held_d;
  logic [7:0]           cnt_q, cnt_d;

  logic [3:0]           hole;
  logic [NUM_HOLES-1:0] hole_bit;
  logic                 ev_mapped;
  logic                 accept;
  logic                 timer_busy;

  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk  (clk),
    .rst  (rst),
    .start(state_q == ST_EMIT),
    .busy (timer_busy)
  );

  always_comb begin
    hole      = code_to_hole(key_code);
    hole_bit  = hole_mask(hole);
    ev_mapped = key_valid && !key_ext && (hole != 4'd0);

    // Held tracking runs in every state; only acceptance is gated by the FSM.
    held_d = held_q;
    if (ev_mapped) begin
      if (key_break) held_d = held_q & ~hole_bit;
      else           held_d = held_q | hole_bit;
    end

    // A make for a key already held is a typematic repeat, not a new press.
    accept = ev_mapped && !key_break && ((held_q & hole_bit) == '0)
             && (state_q == ST_IDLE);

    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_EMIT;
      ST_EMIT:    state_d = ST_LOCKOUT;
      ST_LOCKOUT: if (!timer_busy) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    pos_d = accept ? hole : 4'd0;
    hit_d = accept;
    cnt_d = accept ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pos_q   <= 4'd0;
      hit_q   <= 1'b0;
      held_q  <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hit_q   <= hit_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign one_pulse_pos = pos_q;
  assign hit           = hit_q;
  assign held_mask     = held_q;
  assign press_cnt     = cnt_q;

endmodule
